// File: rtl/fl_distributor.sv
// fl_distributor: FrameLink 1-to-N demux routed by an ID field in the SOF word.
// Define FL_DISTRIB_OUTREG_EN to add a 2-entry output skid buffer (1-cycle latency).
module fl_distributor #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_COUNT = 4,
  parameter int ID_OFFSET    = 0,
  parameter int DREM_WIDTH   = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH/8) : 1,
  parameter int SEL_WIDTH    = $clog2(OUTPUT_COUNT)
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [DATA_WIDTH-1:0]              RX_DATA,
  input  logic [DREM_WIDTH-1:0]              RX_REM,
  input  logic                               RX_SOF_N,
  input  logic                               RX_EOF_N,
  input  logic                               RX_SOP_N,
  input  logic                               RX_EOP_N,
  input  logic                               RX_SRC_RDY_N,
  output logic                               RX_DST_RDY_N,
  output logic [OUTPUT_COUNT*DATA_WIDTH-1:0] TX_DATA,
  output logic [OUTPUT_COUNT*DREM_WIDTH-1:0] TX_REM,
  output logic [OUTPUT_COUNT-1:0]            TX_SOF_N,
  output logic [OUTPUT_COUNT-1:0]            TX_EOF_N,
  output logic [OUTPUT_COUNT-1:0]            TX_SOP_N,
  output logic [OUTPUT_COUNT-1:0]            TX_EOP_N,
  output logic [OUTPUT_COUNT-1:0]            TX_SRC_RDY_N,
  input  logic [OUTPUT_COUNT-1:0]            TX_DST_RDY_N,
  output logic [15:0]                        DROP_CNT
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] sel;
  logic [15:0]          drop_cnt;

  logic [SEL_WIDTH-1:0] id;
  logic [SEL_WIDTH-1:0] dest;
  logic                 id_ok;
  logic                 rx_vld;
  logic                 rx_xfer;
  logic                 route_en;
  logic                 rx_rdy_n;

  assign rx_vld  = ~RX_SRC_RDY_N;
  assign id      = RX_DATA[ID_OFFSET +: SEL_WIDTH];
  assign id_ok   = int'(id) < OUTPUT_COUNT;
  assign rx_xfer = rx_vld & ~rx_rdy_n;

  assign RX_DST_RDY_N = rx_rdy_n;
  assign DROP_CNT     = drop_cnt;

  // route_en: the current input word belongs to an output (dest)
  always_comb begin
    route_en = 1'b0;
    dest     = sel;
    unique case (state)
      IDLE: begin
        if (rx_vld && !RX_SOF_N && id_ok) begin
          route_en = 1'b1;
          dest     = id;
        end
      end
      FWD:     route_en = 1'b1;
      default: route_en = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      sel      <= '0;
      drop_cnt <= '0;
    end else if (rx_xfer) begin
      unique case (state)
        IDLE: begin
          if (!RX_SOF_N) begin
            if (id_ok) begin
              sel   <= id;
              state <= RX_EOF_N ? FWD : IDLE;
            end else begin
              if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
              state <= RX_EOF_N ? DROP : IDLE;
            end
          end
        end
        FWD, DROP: begin
          if (!RX_EOF_N)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef FL_DISTRIB_OUTREG_EN

  always_comb begin
    TX_SRC_RDY_N = '1;
    if (!RESET && route_en)
      TX_SRC_RDY_N[dest] = RX_SRC_RDY_N;
  end

  assign rx_rdy_n = RESET    ? 1'b1 :
                    route_en ? TX_DST_RDY_N[dest] : 1'b0;

  assign TX_DATA  = {OUTPUT_COUNT{RX_DATA}};
  assign TX_REM   = {OUTPUT_COUNT{RX_REM}};
  assign TX_SOF_N = {OUTPUT_COUNT{RX_SOF_N}};
  assign TX_EOF_N = {OUTPUT_COUNT{RX_EOF_N}};
  assign TX_SOP_N = {OUTPUT_COUNT{RX_SOP_N}};
  assign TX_EOP_N = {OUTPUT_COUNT{RX_EOP_N}};

`else

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DREM_WIDTH-1:0] rem;
    logic                  sof_n;
    logic                  eof_n;
    logic                  sop_n;
    logic                  eop_n;
    logic [SEL_WIDTH-1:0]  dest;
  } word_t;

  word_t      mem [2];
  word_t      in_w;
  word_t      head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign in_w = {RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N,
                 RX_SOP_N, RX_EOP_N, dest};
  assign head = mem[rd_ptr];

  // input readiness depends only on occupancy, never on TX_DST_RDY_N
  assign rx_rdy_n = RESET | (cnt == 2'd2);
  assign push     = rx_xfer & route_en;
  assign pop      = !RESET && (cnt != 2'd0) && !TX_DST_RDY_N[head.dest];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_w;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    TX_SRC_RDY_N = '1;
    if (!RESET && cnt != 2'd0)
      TX_SRC_RDY_N[head.dest] = 1'b0;
  end

  assign TX_DATA  = {OUTPUT_COUNT{head.data}};
  assign TX_REM   = {OUTPUT_COUNT{head.rem}};
  assign TX_SOF_N = {OUTPUT_COUNT{head.sof_n}};
  assign TX_EOF_N = {OUTPUT_COUNT{head.eof_n}};
  assign TX_SOP_N = {OUTPUT_COUNT{head.sop_n}};
  assign TX_EOP_N = {OUTPUT_COUNT{head.eop_n}};

`endif

endmodule

// File: tb/tb_fl_distributor.sv
// tb_fl_distributor: vector table, directed sequences and random traffic
// against per-output expected-word queues; d3 instance covers dropping.
module tb_fl_distributor;

  localparam int DW = 32;
  localparam int RW = 2;
  localparam int N4 = 4;
  localparam int N3 = 3;
`ifdef FL_DISTRIB_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam bit FOLLOW = (LAT == 0);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0]    rx_data4;
  logic [RW-1:0]    rx_rem4;
  logic             rx_sof4, rx_eof4, rx_sop4, rx_eop4, rx_src4, rx_dst4;
  logic [N4*DW-1:0] tx_data4;
  logic [N4*RW-1:0] tx_rem4;
  logic [N4-1:0]    tx_sof4, tx_eof4, tx_sop4, tx_eop4, tx_src4;
  logic [N4-1:0]    tx_dst4 = '0;
  logic [15:0]      drop4;

  logic [DW-1:0]    rx_data3;
  logic [RW-1:0]    rx_rem3;
  logic             rx_sof3, rx_eof3, rx_sop3, rx_eop3, rx_src3, rx_dst3;
  logic [N3*DW-1:0] tx_data3;
  logic [N3*RW-1:0] tx_rem3;
  logic [N3-1:0]    tx_sof3, tx_eof3, tx_sop3, tx_eop3, tx_src3;
  logic [N3-1:0]    tx_dst3 = '0;
  logic [15:0]      drop3;

  fl_distributor #(.DATA_WIDTH(DW), .OUTPUT_COUNT(N4)) d4 (
    .CLK(clk), .RESET(rst),
    .RX_DATA(rx_data4), .RX_REM(rx_rem4),
    .RX_SOF_N(rx_sof4), .RX_EOF_N(rx_eof4),
    .RX_SOP_N(rx_sop4), .RX_EOP_N(rx_eop4),
    .RX_SRC_RDY_N(rx_src4), .RX_DST_RDY_N(rx_dst4),
    .TX_DATA(tx_data4), .TX_REM(tx_rem4),
    .TX_SOF_N(tx_sof4), .TX_EOF_N(tx_eof4),
    .TX_SOP_N(tx_sop4), .TX_EOP_N(tx_eop4),
    .TX_SRC_RDY_N(tx_src4), .TX_DST_RDY_N(tx_dst4),
    .DROP_CNT(drop4)
  );

  fl_distributor #(.DATA_WIDTH(DW), .OUTPUT_COUNT(N3)) d3 (
    .CLK(clk), .RESET(rst),
    .RX_DATA(rx_data3), .RX_REM(rx_rem3),
    .RX_SOF_N(rx_sof3), .RX_EOF_N(rx_eof3),
    .RX_SOP_N(rx_sop3), .RX_EOP_N(rx_eop3),
    .RX_SRC_RDY_N(rx_src3), .RX_DST_RDY_N(rx_dst3),
    .TX_DATA(tx_data3), .TX_REM(tx_rem3),
    .TX_SOF_N(tx_sof3), .TX_EOF_N(tx_eof3),
    .TX_SOP_N(tx_sop3), .TX_EOP_N(tx_eop3),
    .TX_SRC_RDY_N(tx_src3), .TX_DST_RDY_N(tx_dst3),
    .DROP_CNT(drop3)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rem;
    logic sof, eof, sop, eop;
  } wrd_t;

  typedef struct {
    int c;
    int o;
  } ev_t;

  typedef struct {
    logic          src_n;
    logic          sof_n;
    logic [DW-1:0] data;
    logic [3:0]    dst_n;
    logic [3:0]    exp_src;
    logic          exp_rdy;
    bit            chk_rdy;
  } vec_t;

  wrd_t expq [N4][$];
  ev_t  log_q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   last_acc = 0;
  int   bp_mode = 0;
  logic tog = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (bp_mode)
      0: tx_dst4 = '0;
      1: tx_dst4 = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      2: begin
        tog     = ~tog;
        tx_dst4 = {tog, 3'b000};
      end
      default: ;
    endcase
  end

  // every d4 transfer must match the head of that output's queue
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < N4; i++) begin
      if (!tx_src4[i] && !tx_dst4[i]) begin
        wrd_t g, e;
        g = {tx_data4[i*DW +: DW], tx_rem4[i*RW +: RW],
             tx_sof4[i], tx_eof4[i], tx_sop4[i], tx_eop4[i]};
        log_q.push_back('{cyc, i});
        ntests++;
        if (expq[i].size() == 0) begin
          nfail++;
          $display("FAIL out%0d_extra got=%h required=none", i, g);
        end else begin
          e = expq[i].pop_front();
          if (g !== e) begin
            nfail++;
            $display("FAIL out%0d_word got=%h required=%h", i, g, e);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
    ntests++;
    if (got !== req) begin
      nfail++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  function automatic int pend();
    return expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size();
  endfunction

  task automatic send_word(input logic [DW-1:0] d, input logic [RW-1:0] r,
                           input logic sof, input logic eof,
                           input bit routed, input int dst,
                           input bit follow);
    bit acc = 1'b0;
    @(negedge clk);
    rx_data4 = d;
    rx_rem4  = r;
    rx_sof4  = sof;
    rx_eof4  = eof;
    rx_sop4  = sof;
    rx_eop4  = eof;
    rx_src4  = 1'b0;
    if (routed)
      expq[dst].push_back({d, r, sof, eof, sof, eof});
    for (int k = 0; k < 200 && !acc; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      if (follow) check("rdy_follow", 32'(rx_dst4), 32'(tx_dst4[3]));
      if (rx_dst4 === 1'b0) begin
        acc      = 1'b1;
        last_acc = cyc;
      end
    end
    if (!acc) begin
      ntests++;
      nfail++;
      $display("FAIL accept_timeout got=stalled required=accept");
    end
  endtask

  task automatic send_frame(input int id, input int len, input bit follow);
    for (int w = 0; w < len; w++) begin
      logic [DW-1:0] d;
      d = $urandom;
      if (w == 0) d[1:0] = 2'(id);
      send_word(d, 2'($urandom_range(0, 3)), w != 0, w != len - 1,
                1'b1, id, follow);
    end
  endtask

  task automatic idle4(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_src4 = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    idle4(1);
    while (k < 100 && pend() != 0) begin
      @(negedge clk);
      #3;
      k++;
    end
    check(nm, 32'(pend()), 32'd0);
  endtask

  vec_t vt [10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, acc, any;
    vt[0] = '{1'b1, 1'b0, 32'h2,        4'h0,    4'hF,    1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 32'h1,        4'h0,    4'hF,    1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 32'h2,        4'h0,    4'b1011, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b0, 32'h3,        4'hF,    4'b0111, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 32'h0,        4'b1110, 4'b1110, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'h1,        4'h0,    4'b1101, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 32'h5,        4'b0010, 4'b1101, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b0, 32'hFFFFFFF7, 4'b0111, 4'b0111, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 32'h2,        4'b0100, 4'b1011, 1'b1, 1'b1};
    vt[9] = '{1'b0, 1'b1, 32'h3,        4'hF,    4'hF,    1'b0, 1'b1};

    rst = 1'b1;
    rx_data4 = 32'h1; rx_rem4 = '0; rx_sof4 = 1'b0; rx_eof4 = 1'b0;
    rx_sop4 = 1'b0; rx_eop4 = 1'b0; rx_src4 = 1'b0;
    rx_data3 = 32'h3; rx_rem3 = '0; rx_sof3 = 1'b0; rx_eof3 = 1'b0;
    rx_sop3 = 1'b0; rx_eop3 = 1'b0; rx_src3 = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("rst_rx_rdy4", 32'(rx_dst4), 32'd1);
      check("rst_tx_src4", 32'(tx_src4), 32'hF);
      check("rst_drop4", 32'(drop4), 32'd0);
      check("rst_drop3", 32'(drop3), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_src4 = 1'b1;
    rx_src3 = 1'b1;

`ifndef FL_DISTRIB_OUTREG_EN
    bp_mode = 3;
    for (int i = 0; i < 10; i++) begin
      int id;
      @(negedge clk);
      rx_src4  = vt[i].src_n;
      rx_sof4  = vt[i].sof_n;
      rx_sop4  = vt[i].sof_n;
      rx_eof4  = 1'b0;
      rx_eop4  = 1'b0;
      rx_data4 = vt[i].data;
      rx_rem4  = 2'(i);
      tx_dst4  = vt[i].dst_n;
      id = int'(vt[i].data[1:0]);
      if (!vt[i].src_n && !vt[i].sof_n && !vt[i].dst_n[id])
        expq[id].push_back({vt[i].data, 2'(i), vt[i].sof_n, 1'b0,
                            vt[i].sof_n, 1'b0});
      #2;
      check($sformatf("vec%0d_tx_src", i), 32'(tx_src4), 32'(vt[i].exp_src));
      if (vt[i].chk_rdy)
        check($sformatf("vec%0d_rx_rdy", i), 32'(rx_dst4), 32'(vt[i].exp_rdy));
    end
    bp_mode = 0;
    drain("vec_drain");
`endif

    // routing: 4-word frame to out 2, then 1-word frame to out 1
    bp_mode = 0;
    idle4(2);
    log_q.delete();
    send_word(32'h00000002, 2'd3, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    first = last_acc;
    send_word(32'hA5A50001, 2'd0, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    send_word(32'h5A5A0003, 2'd1, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    send_word(32'hDEADBEE0, 2'd2, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    send_word(32'h12345671, 2'd1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    drain("route_drain");
    check("route_count", 32'(log_q.size()), 32'd5);
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      check($sformatf("route_out%0d", k), 32'(log_q[k].o),
            (k < 4) ? 32'd2 : 32'd1);
      check($sformatf("route_cyc%0d", k), 32'(log_q[k].c),
            32'(first + LAT + k));
    end

    // backpressure on out 3, toggling 1,0,1,0...
    tog = 1'b0;
    bp_mode = 2;
    send_frame(3, 4, FOLLOW);
    bp_mode = 0;
    drain("bp_drain");

    // random traffic with random backpressure and garbage words
    bp_mode = 1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0)
        send_word($urandom, 2'd0, 1'b1, 1'($urandom_range(0, 1)),
                  1'b0, 0, 1'b0);
      send_frame($urandom_range(0, 3), $urandom_range(1, 5), 1'b0);
      if ($urandom_range(0, 2) == 0)
        idle4($urandom_range(1, 3));
    end
    bp_mode = 0;
    drain("rand_drain");
    check("rand_drop4", 32'(drop4), 32'd0);

    // reset after word 2 of a 5-word frame to out 0
    send_word(32'h11110000, 2'd0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_word(32'h22222222, 2'd1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    rx_data4 = 32'h33333333;
    rx_sof4 = 1'b1; rx_sop4 = 1'b1;
    rx_eof4 = 1'b1; rx_eop4 = 1'b1;
    rx_src4 = 1'b0;
    #2;
    check("midrst_rx_rdy", 32'(rx_dst4), 32'd1);
    check("midrst_tx_src", 32'(tx_src4), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N4; i++) expq[i].delete();
    send_word(32'h44444444, 2'd2, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    send_word(32'h55555555, 2'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(2, 3, 1'b0);
    drain("midrst_drain");

    // drop on 3-output instance: id 3 is out of range
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      rx_data3 = (w == 0) ? 32'hABCD0003 : $urandom;
      rx_sof3 = (w != 0); rx_sop3 = (w != 0);
      rx_eof3 = (w != 2); rx_eop3 = (w != 2);
      rx_src3 = 1'b0;
      #2;
      check($sformatf("drop_rdy%0d", w), 32'(rx_dst3), 32'd0);
      check($sformatf("drop_src%0d", w), 32'(tx_src3), 32'h7);
    end
    @(negedge clk);
    rx_src3 = 1'b1;
    #2;
    check("drop_cnt1", 32'(drop3), 32'd1);

    acc = 0;
    any = 0;
    for (int k = 0; k < 70000 && acc < 65533; k++) begin
      @(negedge clk);
      rx_data3 = 32'h3;
      rx_sof3 = 1'b0; rx_sop3 = 1'b0;
      rx_eof3 = 1'b0; rx_eop3 = 1'b0;
      rx_src3 = 1'b0;
      #2;
      if (tx_src3 !== 3'b111) any = 1;
      if (rx_dst3 === 1'b0) acc++;
    end
    @(negedge clk);
    rx_src3 = 1'b1;
    #2;
    check("drop_bulk_acc", 32'(acc), 32'd65533);
    check("drop_cnt_fffe", 32'(drop3), 32'hFFFE);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rx_src3 = 1'b0;
      #2;
      if (tx_src3 !== 3'b111) any = 1;
    end
    @(negedge clk);
    rx_src3 = 1'b1;
    #2;
    check("drop_cnt_sat", 32'(drop3), 32'hFFFF);
    check("drop_no_tx", 32'(any), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fl_distributor.md
Name: fl_distributor

Overview:
- Demultiplexes one FrameLink stream into OUTPUT_COUNT FrameLink streams. The target output is chosen per frame from an ID field in the first word.
- Downstream counterpart to the FL binder: it takes a bound stream whose header carries the source interface index and restores the per-channel streams.
- Frames with an out-of-range ID are consumed and counted.

Parameters:
- DATA_WIDTH, 32, FrameLink data width in bits (multiple of 8, ≥ 8).
- OUTPUT_COUNT, 4, number of output interfaces (2..16).
- ID_OFFSET, 0, bit position of the LSB of the ID field inside the SOF word.
- DREM_WIDTH, log2(DATA_WIDTH/8), width of the REM signals (derived; do not override).
- SEL_WIDTH, ceil(log2(OUTPUT_COUNT)), width of the ID field (derived).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- RX_DATA  in  DATA_WIDTH  input data.
- RX_REM  in  DREM_WIDTH  input valid-byte index of the last word.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  1 each  frame and part delimiters, active-low.
- RX_SRC_RDY_N  in  1  input valid, active-low.
- RX_DST_RDY_N  out  1  input accept, active-low.
- TX_DATA  out  OUTPUT_COUNT*DATA_WIDTH  output data; slice i belongs to output i.
- TX_REM  out  OUTPUT_COUNT*DREM_WIDTH  per-output REM.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  OUTPUT_COUNT each  per-output delimiters.
- TX_SRC_RDY_N  out  OUTPUT_COUNT  per-output valid, active-low.
- TX_DST_RDY_N  in  OUTPUT_COUNT  per-output accept, active-low.
- DROP_CNT  out  16  count of dropped frames, saturating.

Behaviour:
- A transfer happens on a cycle where the relevant SRC_RDY_N=0 and DST_RDY_N=0.
- Reset (while RESET=1 at a clock edge), regardless of state or frame in progress:
  - FSM goes to IDLE; DROP_CNT=0; sel register=0.
  - RX_DST_RDY_N=1 and all TX_SRC_RDY_N=1 for every cycle in which RESET=1.
  - A partially forwarded frame is abandoned; nothing is replayed.
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - id = RX_DATA[ID_OFFSET+SEL_WIDTH-1 : ID_OFFSET], evaluated combinationally only when RX_SRC_RDY_N=0 and RX_SOF_N=0.
  - Words arriving in IDLE with RX_SOF_N=1 are consumed and discarded (RX_DST_RDY_N=0). They are not counted.
  - id < OUTPUT_COUNT:
    - the SOF word goes to output id;
    - on its transfer, sel<=id;
    - next state is FWD, or stays IDLE if RX_EOF_N=0 on the same word.
  - id ≥ OUTPUT_COUNT:
    - the word is accepted (RX_DST_RDY_N=0) and discarded;
    - DROP_CNT increments on acceptance of the SOF word (saturates at 0xFFFF);
    - next state is DROP, or stays IDLE if EOF is on the same word.
- FWD:
  - TX_SRC_RDY_N[sel]=RX_SRC_RDY_N and RX_DST_RDY_N=TX_DST_RDY_N[sel].
  - All other TX_SRC_RDY_N stay 1. Their DST_RDY_N inputs have no effect.
  - RX_SOF_N is passed through but does not re-route.
  - Returns to IDLE on a transferred word with RX_EOF_N=0.
- DROP:
  - RX_DST_RDY_N=0; all words are discarded.
  - Returns to IDLE on an accepted word with RX_EOF_N=0.
- Data path: DATA, REM and all delimiters are broadcast to every output slice. Only TX_SRC_RDY_N qualifies them.
- Latency and throughput: combinational pass-through, 0 cycles; one word per cycle.
- Back-to-back frames to different outputs: no idle cycle required.
- Timing: no combinational path from TX_DST_RDY_N to any TX_SRC_RDY_N.

Optional Feature:
- Macro: FL_DISTRIB_OUTREG_EN.
- When defined, a 2-entry skid buffer is inserted after the demux.
  - Latency is 1 cycle and throughput stays 1 word per cycle.
  - RX_DST_RDY_N is driven only from buffer occupancy; there is no combinational path from TX_DST_RDY_N to RX_DST_RDY_N.
  - Buffer outputs reset to empty (all TX_SRC_RDY_N=1).
  - DROP_CNT timing is unchanged: it counts at acceptance of the SOF word into the buffer.
- When not defined, the combinational path described under Behaviour applies.

Test Plan:
- Reset: hold RESET for 3 cycles → all TX_SRC_RDY_N=1, RX_DST_RDY_N=1, DROP_CNT=0.
- Routing: 4-word frame with SOF word 0x00000002, then a 1-word frame with id 1, all TX_DST_RDY_N=0 → 4 words appear only on TX[2], then the 1-word frame on TX[1] in the next cycle. REM values match the input.
- Backpressure: frame to TX[3] with TX_DST_RDY_N[3] toggling 1,0,1,0 → RX_DST_RDY_N follows it. No word is lost or duplicated, and data order is preserved.
- Drop:
  - OUTPUT_COUNT=3, 3-word frame with id 3 → consumed in 3 cycles, no TX_SRC_RDY_N asserted, DROP_CNT=1.
  - 65540 such frames → DROP_CNT=0xFFFF.
- Reset mid-frame: assert RESET after word 2 of a 5-word frame to TX[0], then send a new frame with id 2 → the new frame is routed to TX[2] and the remaining old words are not delivered.
- With FL_DISTRIB_OUTREG_EN: repeat the routing scenario → every word appears 1 cycle later, at full throughput, with an identical word stream.
